// File: rtl/pipeline_control_if.sv
// Purpose: control bundle between the pipeline sequencer and the datapath.
//   master : datapath side, drives hazard/handshake inputs, receives controls
//   slave  : pipeline_control side
// Signals: start, load_stall, branch_taken, halt_exec, mem_busy (to sequencer);
//   fetch_en, read_en, exec_en, wb_en, pc_load, exec_bubble, read_bubble,
//   valid[2:0] = {v_read, v_exec, v_wb}, halted, stall_count, flush_count (from sequencer).
interface pipeline_control_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 load_stall;
  logic                 branch_taken;
  logic                 halt_exec;
  logic                 mem_busy;
  logic                 fetch_en;
  logic                 read_en;
  logic                 exec_en;
  logic                 wb_en;
  logic                 pc_load;
  logic                 exec_bubble;
  logic                 read_bubble;
  logic [2:0]           valid;
  logic                 halted;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output start, load_stall, branch_taken, halt_exec, mem_busy,
    input  fetch_en, read_en, exec_en, wb_en, pc_load, exec_bubble, read_bubble,
    input  valid, halted, stall_count, flush_count
  );

  modport slave (
    input  start, load_stall, branch_taken, halt_exec, mem_busy,
    output fetch_en, read_en, exec_en, wb_en, pc_load, exec_bubble, read_bubble,
    output valid, halted, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_control.sv
// Purpose: sequencer for the 4-stage core (fetch -> read -> execute -> writeback).
//   Owns the stage valid bits and pipeline-register enables; turns load-use stalls,
//   taken branches, memory wait states and HALT into freeze/bubble/flush actions.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pipeline_control_if.slave (hazard inputs in, stage controls/status out)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | after reset, nothing fetched, waiting for start
// S_RUN    | pipeline advancing, hazards resolved per cycle
// S_DRAIN  | HALT sits in writeback, retire it and stop
// S_HALTED | core stopped, halted=1, start resumes fetching
module pipeline_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_control_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t               r_state;
  logic [2:0]           r_valid;
  logic                 r_halted;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic w_v_read;
  logic w_v_exec;
  logic w_v_wb;
  logic w_branch;
  logic w_halt;
  logic w_stall;
  logic w_fetch_en;
  logic w_read_en;
  logic w_exec_en;
  logic w_wb_en;
  logic w_pc_load;
  logic w_exec_bubble;
  logic w_read_bubble;

  assign w_v_read = r_valid[2];
  assign w_v_exec = r_valid[1];
  assign w_v_wb   = r_valid[0];

  // Hazards only count when the stage that raises them holds a real instruction.
  assign w_branch = bus.branch_taken & w_v_exec;
  assign w_halt   = bus.halt_exec    & w_v_exec;
  assign w_stall  = bus.load_stall   & w_v_read;

  always_comb begin
    w_fetch_en    = 1'b0;
    w_read_en     = 1'b0;
    w_exec_en     = 1'b0;
    w_wb_en       = 1'b0;
    w_pc_load     = 1'b0;
    w_exec_bubble = 1'b0;
    w_read_bubble = 1'b0;
    case (r_state)
      S_RUN: begin
        // mem_busy freezes every stage, including the writeback gate.
        if (!bus.mem_busy) begin
          w_wb_en = w_v_wb;
          if (w_branch) begin
            // Wrong-path fetch/read contents are flushed; the branch itself retires.
            w_pc_load     = 1'b1;
            w_fetch_en    = 1'b1;
            w_read_bubble = 1'b1;
            w_exec_bubble = 1'b1;
            w_exec_en     = 1'b1;
          end else if (w_halt || w_stall) begin
            w_exec_bubble = 1'b1;
            w_exec_en     = 1'b1;
          end else begin
            w_fetch_en = 1'b1;
            w_read_en  = 1'b1;
            w_exec_en  = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!bus.mem_busy) w_wb_en = w_v_wb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_valid     <= 3'b000;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (!bus.mem_busy) begin
            if (w_branch) begin
              r_valid <= 3'b001;
              if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end else if (w_halt) begin
              r_valid <= 3'b001;
              r_state <= S_DRAIN;
            end else if (w_stall) begin
              r_valid <= {w_v_read, 1'b0, w_v_exec};
              if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end else begin
              r_valid <= {1'b1, w_v_read, w_v_exec};
            end
          end
        end
        S_DRAIN: begin
          if (!bus.mem_busy) begin
            r_state  <= S_HALTED;
            r_valid  <= 3'b000;
            r_halted <= 1'b1;
          end
        end
        S_HALTED: begin
          if (bus.start) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fetch_en    = w_fetch_en;
  assign bus.read_en     = w_read_en;
  assign bus.exec_en     = w_exec_en;
  assign bus.wb_en       = w_wb_en;
  assign bus.pc_load     = w_pc_load;
  assign bus.exec_bubble = w_exec_bubble;
  assign bus.read_bubble = w_read_bubble;
  assign bus.valid       = r_valid;
  assign bus.halted      = r_halted;
  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;
  localparam int CW = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

  typedef logic [42:0] obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_control_if #(.CNT_WIDTH(CW)) bus ();
  pipeline_control #(.CNT_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  obs_t  sb_q[$];
  string tag_q[$];

  int          m_st;
  logic [2:0]  m_v;
  logic        m_h;
  logic [CW-1:0] m_sc, m_fc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic obs_t pack_dut();
    return {bus.fetch_en, bus.read_en, bus.exec_en, bus.wb_en, bus.pc_load,
            bus.exec_bubble, bus.read_bubble, bus.valid, bus.halted,
            bus.stall_count, bus.flush_count};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_v = 3'b000; m_h = 1'b0; m_sc = '0; m_fc = '0;
  endtask

  // Called at posedge+1: drive inputs, predict, compare at negedge, advance model at posedge.
  task automatic cycle(input string tag, input logic st, input logic ls, input logic bt,
                       input logic he, input logic mb);
    logic [6:0] c;   // {fetch, read, exec, wb, pc_load, exec_bubble, read_bubble}
    int act;         // 0 none, 1 branch, 2 halt, 3 stall, 4 advance, 5 retire halt, 6 start
    bus.start = st; bus.load_stall = ls; bus.branch_taken = bt;
    bus.halt_exec = he; bus.mem_busy = mb;
    c = 7'b0; act = 0;
    case (m_st)
      M_IDLE, M_HALTED: if (st) act = 6;
      M_RUN: if (!mb) begin
        if (bt && m_v[1])      begin act = 1; c = {1'b1, 1'b0, 1'b1, m_v[0], 3'b111}; end
        else if (he && m_v[1]) begin act = 2; c = {1'b0, 1'b0, 1'b1, m_v[0], 3'b010}; end
        else if (ls && m_v[2]) begin act = 3; c = {1'b0, 1'b0, 1'b1, m_v[0], 3'b010}; end
        else                   begin act = 4; c = {1'b1, 1'b1, 1'b1, m_v[0], 3'b000}; end
      end
      M_DRAIN: if (!mb) begin act = 5; c = {3'b000, m_v[0], 3'b000}; end
      default: ;
    endcase
    sb_q.push_back({c, m_v, m_h, m_sc, m_fc});
    tag_q.push_back(tag);
    @(negedge clk);
    check(tag_q.pop_front(), 64'(pack_dut()), 64'(sb_q.pop_front()));
    @(posedge clk);
    case (act)
      1: begin m_v = 3'b001; if (m_fc != '1) m_fc++; end
      2: begin m_v = 3'b001; m_st = M_DRAIN; end
      3: begin m_v = {m_v[2], 1'b0, m_v[1]}; if (m_sc != '1) m_sc++; end
      4: m_v = {1'b1, m_v[2], m_v[1]};
      5: begin m_st = M_HALTED; m_v = 3'b000; m_h = 1'b1; end
      6: begin m_st = M_RUN; m_h = 1'b0; end
      default: ;
    endcase
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.load_stall = 0; bus.branch_taken = 0;
    bus.halt_exec = 0; bus.mem_busy = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset", 64'(pack_dut()), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: fill from reset
    cycle("t1_idle", 0, 0, 0, 0, 0);
    cycle("t1_start", 1, 0, 0, 0, 0);
    check("t1_v0", 64'(bus.valid), 64'b000);
    cycle("t1_fill1", 0, 0, 0, 0, 0);
    check("t1_v1", 64'(bus.valid), 64'b100);
    cycle("t1_fill2", 0, 0, 0, 0, 0);
    check("t1_v2", 64'(bus.valid), 64'b110);
    cycle("t1_fill3", 0, 0, 0, 0, 0);
    check("t1_v3", 64'(bus.valid), 64'b111);
    check("t1_steady_en", 64'({bus.fetch_en, bus.read_en, bus.exec_en, bus.wb_en}), 64'hf);
    cycle("t1_run_start_ignored", 1, 0, 0, 0, 0);

    // 2: single load-use stall
    cycle("t2_stall", 0, 1, 0, 0, 0);
    check("t2_valid", 64'(bus.valid), 64'b101);
    check("t2_stall_cnt", 64'(bus.stall_count), 64'd1);
    for (int i = 0; i < 2; i++) cycle("t2_refill", 0, 0, 0, 0, 0);

    // 3: branch wins over same-cycle load stall
    cycle("t3_br_ls", 0, 1, 1, 0, 0);
    check("t3_valid", 64'(bus.valid), 64'b001);
    check("t3_flush_cnt", 64'(bus.flush_count), 64'd1);
    check("t3_stall_cnt", 64'(bus.stall_count), 64'd1);
    for (int i = 0; i < 3; i++) cycle("t3_refill", 0, 0, 0, 0, 0);

    // 4: mem_busy freezes a pending branch for three cycles
    for (int i = 0; i < 3; i++) cycle("t4_busy", 0, 0, 1, 0, 1);
    check("t4_flush_frozen", 64'(bus.flush_count), 64'd1);
    cycle("t4_branch", 0, 0, 1, 0, 0);
    check("t4_flush_cnt", 64'(bus.flush_count), 64'd2);
    for (int i = 0; i < 3; i++) cycle("t4_refill", 0, 0, 0, 0, 0);

    // 5: halt, drain, restart
    cycle("t5_halt", 0, 0, 0, 1, 0);
    check("t5_drain_wb", 64'(bus.wb_en), 64'd1);
    cycle("t5_drain", 0, 0, 0, 0, 0);
    check("t5_halted", 64'(bus.halted), 64'd1);
    cycle("t5_halted_wait", 0, 0, 0, 0, 0);
    cycle("t5_restart", 1, 0, 0, 0, 0);
    check("t5_v0", 64'({bus.valid, bus.halted}), 64'b0000);
    cycle("t5_fill1", 0, 0, 0, 0, 0);
    check("t5_v1", 64'(bus.valid), 64'b100);

    // 6a: async reset in the middle of DRAIN
    cycle("t6_fill2", 0, 0, 0, 0, 0);
    cycle("t6_halt", 0, 0, 0, 1, 0);
    cycle("t6_drain_busy", 0, 0, 0, 0, 1);
    idle_inputs();
    #1 rst_n = 1'b0;
    #1 check("t6_async_reset", 64'(pack_dut()), 64'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 6b: stall counter saturation
    cycle("t6_start", 1, 0, 0, 0, 0);
    cycle("t6_fill", 0, 0, 0, 0, 0);
    for (int i = 0; i < (1 << CW) + 5; i++) cycle("t6_sat_stall", 0, 1, 0, 0, 0);
    check("t6_stall_sat", 64'(bus.stall_count), 64'hffff);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
